uart_tx_serializer: RTL and testbench

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_tick.sv | 43 ++++
 rtl/uart_tx_serializer.sv | 142 ++++++++++++++
 tb/tb_uart_tx_serializer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and default baud divisor.
package uart_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    // Narrower payloads are zero-extended, which leaves the XOR unchanged.
    function automatic logic parity_bit(input logic [7:0] data, input int unsigned mode);
        return (^data) ^ (mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: o_tick is high in the last cycle of every CLKS_PER_BIT-cycle period.
// i_restart holds the period at its start so the next bit begins cleanly.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
)(
    input  logic i_clk,
    input  logic i_arst,
    input  logic i_restart,
    output logic o_tick,
    output logic o_tick_nxt_c
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_tick;

    // Down-counter reloads at every bit boundary, so it never passes zero.
    always_comb begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (i_restart || (r_cnt == '0)) begin
            w_cnt_nxt = RELOAD;
        end
    end

    assign o_tick_nxt_c = (w_cnt_nxt == '0);
    assign o_tick       = r_tick;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_tick <= o_tick_nxt_c;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// AXI-Stream to UART transmitter: start bit, LSB-first data, optional parity, 1-2 stop bits.
// All outputs come from flops loaded with next-state values, so o_txd has no input-to-output path.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT      = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned G_AXIS_TDATA_SIZE = 8,
    parameter int unsigned PARITY            = PARITY_NONE,
    parameter int unsigned STOP_BITS         = 1
)(
    input  logic                         i_clk,
    input  logic                         i_arst,
    input  logic                         i_s_axis_tvalid,
    output logic                         o_s_axis_tready,
    input  logic [G_AXIS_TDATA_SIZE-1:0] i_s_axis_tdata,
    output logic                         o_txd,
    output logic                         o_txd_busy,
    output logic                         o_txd_done
);

    localparam int unsigned      BIT_W     = $clog2(G_AXIS_TDATA_SIZE);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(G_AXIS_TDATA_SIZE - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_t                    r_state;
    tx_state_t                    w_state_nxt;
    logic [G_AXIS_TDATA_SIZE-1:0] r_data;
    logic [G_AXIS_TDATA_SIZE-1:0] w_data_nxt;
    logic [BIT_W-1:0]             r_bit_idx;
    logic [BIT_W-1:0]             w_bit_nxt;
    logic                         r_stop_idx;
    logic                         w_stop_nxt;
    logic                         r_tready;
    logic                         r_txd;
    logic                         r_busy;
    logic                         r_done;
    logic                         w_txd_nxt;
    logic                         w_done_nxt;
    logic                         w_restart;
    logic                         w_tick;
    logic                         w_tick_nxt;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .i_clk        (i_clk),
        .i_arst       (i_arst),
        .i_restart    (w_restart),
        .o_tick       (w_tick),
        .o_tick_nxt_c (w_tick_nxt)
    );

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_state    <= ST_IDLE;
            r_data     <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_tready   <= 1'b0;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_data     <= w_data_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_stop_idx <= w_stop_nxt;
            r_tready   <= (w_state_nxt == ST_IDLE);
            r_txd      <= w_txd_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_bit_nxt   = r_bit_idx;
        w_stop_nxt  = r_stop_idx;
        w_restart   = 1'b0;
        w_txd_nxt   = 1'b1;
        w_done_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_restart = 1'b1;
                if (i_s_axis_tvalid && r_tready) begin
                    w_data_nxt  = i_s_axis_tdata;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_bit_nxt   = '0;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == LAST_BIT) begin
                        w_stop_nxt  = 1'b0;
                        w_state_nxt = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        w_bit_nxt = r_bit_idx + BIT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick) begin
                    w_stop_nxt  = 1'b0;
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_stop_idx == LAST_STOP) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_stop_nxt = r_stop_idx + 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Line level for the cycle we are about to enter.
        case (w_state_nxt)
            ST_START:  w_txd_nxt = 1'b0;
            ST_DATA:   w_txd_nxt = w_data_nxt[w_bit_nxt];
            ST_PARITY: w_txd_nxt = parity_bit(8'(w_data_nxt), PARITY);
            default:   w_txd_nxt = 1'b1;
        endcase

        w_done_nxt = (w_state_nxt == ST_STOP) && (w_stop_nxt == LAST_STOP) && w_tick_nxt;
    end

    assign o_s_axis_tready = r_tready;
    assign o_txd           = r_txd;
    assign o_txd_busy      = r_busy;
    assign o_txd_done      = r_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench: five serializer configurations, directed + random bytes, each frame
// compared cycle by cycle against a waveform built from the UART framing rules.
module tb_uart_tx_serializer;

    localparam int NI = 5;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [NI-1:0] tvalid;
    logic [NI-1:0] tready;
    logic [NI-1:0] txd;
    logic [NI-1:0] busy;
    logic [NI-1:0] done;
    logic [7:0]    tdata [NI];

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int pushed  [NI];
    int checked [NI];
    int hs_cyc  [NI];

    // Instance configurations: 0 plain, 1 even, 2 odd, 3 even + 2 stop, 4 one clock per bit.
    function automatic int cfg_clks(input int g);
        return (g == 4) ? 1 : 4;
    endfunction
    function automatic int cfg_par(input int g);
        case (g)
            1:       return 2;
            2:       return 1;
            3:       return 2;
            default: return 0;
        endcase
    endfunction
    function automatic int cfg_stop(input int g);
        return (g == 3) ? 2 : 1;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input int inst, input bit ok, input string nm,
                         input longint act, input longint exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL u%0d %s actual=%0d expected=%0d (cycle %0d)", inst, nm, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int C = cfg_clks(g);
        localparam int P = cfg_par(g);
        localparam int S = cfg_stop(g);

        uart_tx_serializer #(
            .CLKS_PER_BIT      (C),
            .G_AXIS_TDATA_SIZE (8),
            .PARITY            (P),
            .STOP_BITS         (S)
        ) u_dut (
            .i_clk           (clk),
            .i_arst          (rst),
            .i_s_axis_tvalid (tvalid[g]),
            .o_s_axis_tready (tready[g]),
            .i_s_axis_tdata  (tdata[g]),
            .o_txd           (txd[g]),
            .o_txd_busy      (busy[g]),
            .o_txd_done      (done[g])
        );

        exp_t q[$];
        bit   wave[$];
        int   pos    = 0;
        bit   active = 1'b0;
        int   nrst   = 0;

        // Stimulus side: every accepted byte becomes an expected frame.
        always @(negedge clk) begin
            if (!rst && tvalid[g] && tready[g]) begin
                q.push_back('{data: tdata[g], cyc: cyc});
                pushed[g]++;
                hs_cyc[g] = cyc;
            end
        end

        always @(negedge clk) begin : mon
            exp_t e;
            if (rst) begin
                check(g, txd[g] === 1'b1, "rst_txd", longint'(txd[g]), 1);
                check(g, busy[g] === 1'b0, "rst_busy", longint'(busy[g]), 0);
                check(g, done[g] === 1'b0, "rst_done", longint'(done[g]), 0);
                check(g, tready[g] === 1'b0, "rst_tready", longint'(tready[g]), 0);
                checked[g] += q.size();
                q.delete();
                active = 1'b0;
                nrst   = 0;
            end else begin
                if (!active && (txd[g] !== 1'b1 || busy[g] !== 1'b0)) begin
                    check(g, q.size() != 0, "unexpected_frame", q.size(), 1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        checked[g]++;
                        check(g, cyc == e.cyc + 1, "start_latency", cyc, e.cyc + 1);
                        wave.delete();
                        repeat (C) wave.push_back(1'b0);
                        for (int i = 0; i < 8; i++) repeat (C) wave.push_back(e.data[i]);
                        if (P != 0) repeat (C) wave.push_back((^e.data) ^ (P == 1));
                        repeat (S * C) wave.push_back(1'b1);
                        active = 1'b1;
                        pos    = 0;
                    end
                end
                if (active) begin
                    check(g, txd[g] === wave[pos], "txd_bit", longint'(txd[g]), longint'(wave[pos]));
                    check(g, busy[g] === 1'b1, "frame_busy", longint'(busy[g]), 1);
                    check(g, tready[g] === 1'b0, "frame_tready", longint'(tready[g]), 0);
                    check(g, done[g] === (pos == wave.size() - 1), "frame_done",
                          longint'(done[g]), longint'(pos == wave.size() - 1));
                    pos++;
                    if (pos == wave.size()) active = 1'b0;
                end else begin
                    check(g, done[g] === 1'b0, "idle_done", longint'(done[g]), 0);
                    check(g, tready[g] === (nrst != 0), "idle_tready",
                          longint'(tready[g]), longint'(nrst != 0));
                end
                nrst++;
            end
        end
    end

    // Waits for tready while scrambling tdata, which a frame in flight must ignore.
    task automatic wait_ready(input int k, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (tready[k]) begin
                ok = 1'b1;
                break;
            end
            tdata[k] = 8'($urandom);
            @(posedge clk); #1;
        end
        check(k, ok, "ready_timeout", longint'(ok), 1);
    endtask

    task automatic send(input int k, input logic [7:0] b);
        bit ok;
        wait_ready(k, ok);
        if (ok) begin
            tvalid[k] = 1'b1;
            tdata[k]  = b;
            @(posedge clk); #1;
            tvalid[k] = 1'b0;
            tdata[k]  = ~b;
        end
    endtask

    task automatic back_to_back(input int k, input logic [7:0] b0, input logic [7:0] b1,
                                input int gap);
        bit ok;
        int h0;
        wait_ready(k, ok);
        if (ok) begin
            tvalid[k] = 1'b1;
            tdata[k]  = b0;
            @(posedge clk); #1;
            h0       = hs_cyc[k];
            tdata[k] = b1;
            ok       = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(posedge clk); #1;
                if (hs_cyc[k] != h0) begin
                    ok = 1'b1;
                    break;
                end
            end
            tvalid[k] = 1'b0;
            check(k, ok, "b2b_timeout", longint'(ok), 1);
            if (ok) check(k, hs_cyc[k] - h0 == gap, "b2b_gap", hs_cyc[k] - h0, gap);
        end
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < NI; k++) tdata[k] = 8'($urandom);
            @(posedge clk); #1;
            if (busy == '0 && tready == '1) begin
                ok = 1'b1;
                break;
            end
        end
        check(0, ok, "drain_timeout", longint'(ok), 1);
    endtask

    initial begin
        rst    = 1'b1;
        tvalid = '0;
        for (int k = 0; k < NI; k++) begin
            tdata[k]   = 8'h00;
            pushed[k]  = 0;
            checked[k] = 0;
            hs_cyc[k]  = 0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        send(0, 8'h55);
        send(1, 8'h07);
        send(2, 8'h07);
        send(4, 8'hFF);
        back_to_back(3, 8'hA3, 8'h3C, (1 + 8 + 1 + 2) * 4 + 1);
        drain();

        // Abort a frame in data bit 3 (line low for 0x96) with an unaligned reset.
        send(0, 8'h96);
        repeat (16) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check(0, txd[0] === 1'b1, "abort_txd", longint'(txd[0]), 1);
        check(0, busy[0] === 1'b0, "abort_busy", longint'(busy[0]), 0);
        check(0, done[0] === 1'b0, "abort_done", longint'(done[0]), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        send(0, 8'hC5);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < NI; k++) send(k, 8'($urandom));
        end
        back_to_back(3, 8'($urandom), 8'($urandom), (1 + 8 + 1 + 2) * 4 + 1);
        drain();
        repeat (2) @(posedge clk);

        for (int k = 0; k < NI; k++) begin
            check(k, pushed[k] == checked[k], "frames_seen", checked[k], pushed[k]);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
